regfile_mp_lm: RTL

- Parametrised successor to the ARM register-file I/O block: NUM_RD combinational read ports and two write ports.
  - Port 0: ALU/load writeback.
  - Port 1: base-register update.
- Optional write-to-read bypass.
- PC register reads as the external PC plus a pipeline offset.
- Built-in LDM/STM register-list sequencer that generates the register index stream formerly supplied externally.
- Sits between the decode/control unit and the datapath.

---
 rtl/rf_pkg.sv | 38 +++
 rtl/lm_sequencer.sv | 97 +++++++++
 rtl/regfile_mp_lm.sv | 105 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register file and its load/store-multiple
// register-list sequencer.
//   PC_IDX_DEF / PC_OFFSET_DEF : default PC alias index and read offset
//   lm_state_t                 : sequencer state encoding
//   popcount / lowest_set_index: helpers over a register-list bitmap
//                                (zero-extended to LIST_MAX bits)
package rf_pkg;

  localparam int PC_IDX_DEF    = 15;
  localparam int PC_OFFSET_DEF = 8;
  localparam int LIST_MAX      = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lm_state_t;

  function automatic int unsigned popcount(input logic [LIST_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < LIST_MAX; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  // Returns 0 for an empty list; callers only use it on non-empty lists.
  function automatic int lowest_set_index(input logic [LIST_MAX-1:0] v);
    int idx;
    idx = 0;
    for (int i = LIST_MAX - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/lm_sequencer.sv
// Register-list sequencer for load/store-multiple. Captures a register bitmap
// and emits the set indices lowest first, one per accepted lm_adv.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   lm_start, lm_list: start request and register bitmap (taken in IDLE only)
//   lm_adv           : consumer accepts the current lm_reg (used in RUN only)
//   lm_valid, lm_reg : current index and its qualifier
//   lm_last          : current index is the final one of the list
//   lm_count         : popcount of the captured list
//   lm_done, lm_busy : one-cycle completion pulse, sequencer not idle
//
// state | meaning
// IDLE  | waiting for lm_start
// RUN   | presenting lm_reg, advancing on lm_adv
// DONE  | one-cycle completion pulse, then IDLE
module lm_sequencer
  import rf_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lm_start,
  input  logic [NUM_REGS-1:0] lm_list,
  input  logic                lm_adv,
  output logic                lm_valid,
  output logic [ADDR_W-1:0]   lm_reg,
  output logic                lm_last,
  output logic [ADDR_W:0]     lm_count,
  output logic                lm_done,
  output logic                lm_busy
);

  lm_state_t           r_state;
  logic [NUM_REGS-1:0] r_shadow;
  logic [ADDR_W-1:0]   r_reg;
  logic [ADDR_W:0]     r_count;

  logic [NUM_REGS-1:0] w_next_shadow;
  logic [LIST_MAX-1:0] w_list_ext;
  logic [LIST_MAX-1:0] w_next_ext;
  logic                w_one_left;

  // The current index is always the lowest shadow bit, so clearing the
  // lowest set bit retires it.
  assign w_next_shadow = r_shadow & (r_shadow - NUM_REGS'(1));
  assign w_one_left    = (r_shadow != '0) && (w_next_shadow == '0);

  always_comb begin
    w_list_ext                 = '0;
    w_list_ext[NUM_REGS-1:0]   = lm_list;
    w_next_ext                 = '0;
    w_next_ext[NUM_REGS-1:0]   = w_next_shadow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_reg    <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (lm_start) begin
            r_shadow <= lm_list;
            r_count  <= (ADDR_W+1)'(popcount(w_list_ext));
            if (lm_list != '0) begin
              r_state <= RUN;
              r_reg   <= ADDR_W'(lowest_set_index(w_list_ext));
            end else begin
              r_state <= DONE;
            end
          end
        end
        RUN: begin
          if (lm_adv) begin
            r_shadow <= w_next_shadow;
            if (w_one_left) r_state <= DONE;
            else            r_reg   <= ADDR_W'(lowest_set_index(w_next_ext));
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign lm_valid = (r_state == RUN);
  assign lm_busy  = (r_state != IDLE);
  assign lm_done  = (r_state == DONE);
  assign lm_last  = lm_valid && w_one_left;
  assign lm_reg   = r_reg;
  assign lm_count = r_count;

endmodule

// File: rtl/regfile_mp_lm.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports
// (wr0 = ALU/load writeback, wr1 = base update), optional write-to-read
// bypass, PC alias reading pc_in + PC_OFFSET, and an LDM/STM sequencer.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   rd_addr / rd_data   : packed read indices / data, port k at slice k
//   pc_in               : current fetch PC
//   wr0_* / wr1_*       : write ports; wr0 wins on an index collision
//   pc_ld               : wr0 is targeting the PC index this cycle
//   lm_*                : register-list sequencer interface
module regfile_mp_lm
  import rf_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int NUM_REGS  = 16,
  parameter int NUM_RD    = 3,
  parameter int PC_IDX    = PC_IDX_DEF,
  parameter int PC_OFFSET = PC_OFFSET_DEF,
  parameter int BYPASS    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0]        pc_in,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  output logic                     pc_ld,
  input  logic                     lm_start,
  input  logic [NUM_REGS-1:0]      lm_list,
  input  logic                     lm_adv,
  output logic                     lm_valid,
  output logic [ADDR_W-1:0]        lm_reg,
  output logic                     lm_last,
  output logic [ADDR_W:0]          lm_count,
  output logic                     lm_done,
  output logic                     lm_busy
);

  localparam logic [ADDR_W:0]   NUM_REGS_A = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] PC_IDX_A   = ADDR_W'(PC_IDX);
  localparam logic [DATA_W-1:0] PC_OFF_D   = DATA_W'(PC_OFFSET);
  localparam bit                BYP        = (BYPASS != 0);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic w_wr0_ok;
  logic w_wr1_ok;

  // Only in-range, non-PC indices ever reach the array.
  assign w_wr0_ok = wr0_en && ({1'b0, wr0_addr} < NUM_REGS_A) && (wr0_addr != PC_IDX_A);
  assign w_wr1_ok = wr1_en && ({1'b0, wr1_addr} < NUM_REGS_A) && (wr1_addr != PC_IDX_A);
  assign pc_ld    = wr0_en && (wr0_addr == PC_IDX_A);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      // wr0 is assigned last so it wins a same-index collision.
      if (w_wr1_ok) r_regs[wr1_addr] <= wr1_data;
      if (w_wr0_ok) r_regs[wr0_addr] <= wr0_data;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] w_ra;
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      w_ra = rd_addr[k*ADDR_W +: ADDR_W];
      if (w_ra == PC_IDX_A)
        rd_data[k*DATA_W +: DATA_W] = pc_in + PC_OFF_D;
      else if ({1'b0, w_ra} >= NUM_REGS_A)
        rd_data[k*DATA_W +: DATA_W] = '0;
      else if (BYP && wr0_en && (wr0_addr == w_ra))
        rd_data[k*DATA_W +: DATA_W] = wr0_data;
      else if (BYP && wr1_en && (wr1_addr == w_ra))
        rd_data[k*DATA_W +: DATA_W] = wr1_data;
      else
        rd_data[k*DATA_W +: DATA_W] = r_regs[w_ra];
    end
  end

  lm_sequencer #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_lm_seq (
    .clk      (clk),
    .reset    (reset),
    .lm_start (lm_start),
    .lm_list  (lm_list),
    .lm_adv   (lm_adv),
    .lm_valid (lm_valid),
    .lm_reg   (lm_reg),
    .lm_last  (lm_last),
    .lm_count (lm_count),
    .lm_done  (lm_done),
    .lm_busy  (lm_busy)
  );

endmodule
